// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
// Shared definitions for the UART frame parser: parser state encoding,
// error codes reported on o_Err_Code, and the default start-of-frame byte.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC   = 2'd0,
    GET_LEN     = 2'd1,
    GET_PAYLOAD = 2'd2,
    GET_CSUM    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf
// Payload buffer: DEPTH x 8 RAM with synchronous write and asynchronous read.
// Ports:
//   i_Clock  - system clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write byte
//   rd_addr  - read address
//   rd_data  - byte at rd_addr (combinational)
module uart_frame_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would force flops
  // instead of RAM, and its contents are only meaningful once a frame lands.
  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Assembles SYNC / LEN / payload / CSUM frames from a UART receiver's byte
// strobe. A validated payload is held in uart_frame_buf until the consumer
// acknowledges it; malformed frames produce a one-cycle error pulse.
// Ports:
//   i_Clock, i_Reset_n      - clock, asynchronous active-low reset
//   i_RX_DV, i_RX_Byte      - received byte and its one-cycle valid strobe
//   o_Frame_Ready           - held frame available (level until ack)
//   i_Frame_Ack             - consumer releases the buffer
//   o_Frame_Len             - payload length of the held frame
//   i_Rd_Addr, o_Rd_Data    - combinational buffer read port
//   o_Err, o_Err_Code       - error pulse and its code (code holds afterwards)
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 8680,
  localparam int        ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_Frame_Ready,
  input  logic              i_Frame_Ack,
  output logic [7:0]        o_Frame_Len,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output logic [7:0]        o_Rd_Data,
  output logic              o_Err,
  output logic [1:0]        o_Err_Code
);

  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

  state_t          state;
  logic [7:0]      len;
  logic [7:0]      idx;
  logic [7:0]      csum;
  logic            dropped;
  logic [TO_W-1:0] to_cnt;

  logic timeout_hit;
  logic buf_wr;

  // A byte on the timeout cycle takes priority, so timeout needs an idle cycle.
  assign timeout_hit = (state != WAIT_SYNC) && !i_RX_DV &&
                       (to_cnt == TO_W'(TIMEOUT_CLKS - 1));

  // Payload bytes only land while the buffer is free; otherwise they are lost.
  assign buf_wr = i_RX_DV && (state == GET_PAYLOAD) && !o_Frame_Ready;

  uart_frame_buf #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .i_Clock (i_Clock),
    .wr_en   (buf_wr),
    .wr_addr (idx[ADDR_W-1:0]),
    .wr_data (i_RX_Byte),
    .rd_addr (i_Rd_Addr),
    .rd_data (o_Rd_Data)
  );

  // NOTE: all state here updates with non-blocking assignments so every
  // branch sees the pre-edge values (e.g. ack clear vs. CSUM set below).
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= WAIT_SYNC;
      len           <= '0;
      idx           <= '0;
      csum          <= '0;
      dropped       <= 1'b0;
      to_cnt        <= '0;
      o_Frame_Ready <= 1'b0;
      o_Frame_Len   <= '0;
      o_Err         <= 1'b0;
      o_Err_Code    <= '0;
    end else begin
      o_Err <= 1'b0;

      // Ack clears; a successful CSUM later in this block overrides it.
      if (o_Frame_Ready && i_Frame_Ack) o_Frame_Ready <= 1'b0;

      if (i_RX_DV || state == WAIT_SYNC || timeout_hit) to_cnt <= '0;
      else                                                to_cnt <= to_cnt + TO_W'(1);

      if (i_RX_DV) begin
        unique case (state)
          WAIT_SYNC: begin
            if (i_RX_Byte == SYNC_BYTE) begin
              state   <= GET_LEN;
              dropped <= 1'b0;
            end
          end

          GET_LEN: begin
            if (i_RX_Byte == 8'd0 || i_RX_Byte > 8'(MAX_LEN)) begin
              o_Err      <= 1'b1;
              o_Err_Code <= ERR_LEN;
              state      <= WAIT_SYNC;
            end else begin
              len   <= i_RX_Byte;
              csum  <= i_RX_Byte;
              idx   <= '0;
              state <= GET_PAYLOAD;
            end
          end

          GET_PAYLOAD: begin
            csum <= csum ^ i_RX_Byte;
            idx  <= idx + 8'd1;
            if (o_Frame_Ready) dropped <= 1'b1;
            if (idx == len - 8'd1) state <= GET_CSUM;
          end

          GET_CSUM: begin
            state <= WAIT_SYNC;
            if (dropped) begin
              o_Err      <= 1'b1;
              o_Err_Code <= ERR_OVERRUN;
            end else if (i_RX_Byte != csum) begin
              o_Err      <= 1'b1;
              o_Err_Code <= ERR_CSUM;
            end else begin
              o_Frame_Ready <= 1'b1;
              o_Frame_Len   <= len;
            end
          end

          default: state <= WAIT_SYNC;
        endcase
      end else if (timeout_hit) begin
        o_Err      <= 1'b1;
        o_Err_Code <= ERR_TIMEOUT;
        state      <= WAIT_SYNC;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
// Directed scenarios plus randomized frames, checked every clock against a
// queue-based reference model of the framing rules.
module tb_uart_frame_parser;
  import uart_frame_pkg::*;

  localparam int         MAX_LEN      = 16;
  localparam int         TIMEOUT_CLKS = 200;
  localparam int         AW           = $clog2(MAX_LEN);
  localparam logic [7:0] SYNC         = 8'hA5;

  logic          i_Clock = 1'b0;
  logic          i_Reset_n;
  logic          i_RX_DV;
  logic [7:0]    i_RX_Byte;
  logic          o_Frame_Ready;
  logic          i_Frame_Ack;
  logic [7:0]    o_Frame_Len;
  logic [AW-1:0] i_Rd_Addr;
  logic [7:0]    o_Rd_Data;
  logic          o_Err;
  logic [1:0]    o_Err_Code;

  always #5 i_Clock = ~i_Clock;

  uart_frame_parser #(
    .SYNC_BYTE    (SYNC),
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .i_Clock       (i_Clock),
    .i_Reset_n     (i_Reset_n),
    .i_RX_DV       (i_RX_DV),
    .i_RX_Byte     (i_RX_Byte),
    .o_Frame_Ready (o_Frame_Ready),
    .i_Frame_Ack   (i_Frame_Ack),
    .o_Frame_Len   (o_Frame_Len),
    .i_Rd_Addr     (i_Rd_Addr),
    .o_Rd_Data     (o_Rd_Data),
    .o_Err         (o_Err),
    .o_Err_Code    (o_Err_Code)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit rand_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the frame in progress is a byte queue (SYNC, LEN, payload...).
  logic [7:0] fq[$];
  int         m_idle;
  bit         m_lost;
  bit         m_ready;
  logic [7:0] m_len;
  logic [1:0] m_code;
  bit         m_err;
  logic [7:0] m_buf [MAX_LEN];

  task automatic model_reset();
    fq.delete();
    m_idle  = 0;
    m_lost  = 0;
    m_ready = 0;
    m_len   = 8'd0;
    m_code  = 2'd0;
    m_err   = 0;
  endtask

  task automatic model_flag(input logic [1:0] code);
    m_err  = 1;
    m_code = code;
  endtask

  task automatic model_step(input bit dv, input logic [7:0] b, input bit ack);
    bit         nr;
    logic [7:0] x;
    nr    = m_ready;
    m_err = 0;
    if (m_ready && ack) nr = 0;
    if (dv) begin
      m_idle = 0;
      if (fq.size() == 0) begin
        if (b == SYNC) begin
          fq.push_back(b);
          m_lost = 0;
        end
      end else if (fq.size() == 1) begin
        if (b == 8'd0 || b > MAX_LEN) begin
          model_flag(ERR_LEN);
          fq.delete();
        end else begin
          fq.push_back(b);
        end
      end else if (fq.size() < int'(fq[1]) + 2) begin
        if (m_ready) m_lost = 1;
        else         m_buf[fq.size() - 2] = b;
        fq.push_back(b);
      end else begin
        x = 8'd0;
        for (int i = 1; i < fq.size(); i++) x ^= fq[i];
        if (m_lost)      model_flag(ERR_OVERRUN);
        else if (x != b) model_flag(ERR_CSUM);
        else begin
          nr    = 1;
          m_len = fq[1];
        end
        fq.delete();
      end
    end else if (fq.size() != 0) begin
      m_idle++;
      if (m_idle == TIMEOUT_CLKS) begin
        model_flag(ERR_TIMEOUT);
        fq.delete();
      end
    end
    m_ready = nr;
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge.
  task automatic cycle(input bit dv, input logic [7:0] b, input bit ack);
    logic [AW-1:0] a;
    a           = AW'($urandom_range(0, MAX_LEN - 1));
    i_RX_DV     = dv;
    i_RX_Byte   = b;
    i_Frame_Ack = ack;
    i_Rd_Addr   = a;
    model_step(dv, b, ack);
    @(posedge i_Clock);
    #1;
    i_RX_DV     = 1'b0;
    i_Frame_Ack = 1'b0;
    check("err", o_Err, m_err);
    check("err_code", o_Err_Code, m_code);
    check("ready", o_Frame_Ready, m_ready);
    check("len", o_Frame_Len, m_len);
    if (m_ready && a < m_len) check("rd_data", o_Rd_Data, m_buf[a]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rand_ack && ($urandom_range(0, 15) == 0));
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i], $urandom_range(0, 2));
  endtask

  task automatic ack();
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic peek(input int a, input logic [7:0] exp, input string tag);
    i_Rd_Addr = AW'(a);
    #1;
    check(tag, o_Rd_Data, exp);
  endtask

  task automatic do_reset();
    i_RX_DV     = 1'b0;
    i_Frame_Ack = 1'b0;
    i_Reset_n   = 1'b0;
    #1;
    check("rst_ready", o_Frame_Ready, 1'b0);
    check("rst_len", o_Frame_Len, 8'd0);
    check("rst_err", o_Err, 1'b0);
    check("rst_code", o_Err_Code, 2'd0);
    model_reset();
    @(posedge i_Clock);
    #1;
    i_Reset_n = 1'b1;
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 2) return TIMEOUT_CLKS - 1;
    if (r < 4) return TIMEOUT_CLKS;
    return r % 3;
  endfunction

  task automatic random_frame();
    int         kind;
    int         len;
    int         cut;
    logic [7:0] fr[$];
    logic [7:0] cs;
    logic [7:0] p;
    kind = $urandom_range(0, 9);
    len  = $urandom_range(1, MAX_LEN);
    fr.delete();
    if (kind == 8) begin
      for (int i = 0; i < $urandom_range(1, 5); i++) fr.push_back(8'($urandom_range(0, 255)));
    end else if (kind == 7) begin
      fr.push_back(SYNC);
      fr.push_back($urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
    end else begin
      fr.push_back(SYNC);
      fr.push_back(8'(len));
      cs = 8'(len);
      for (int i = 0; i < len; i++) begin
        p = 8'($urandom_range(0, 255));
        fr.push_back(p);
        cs ^= p;
      end
      if (kind == 6) cs ^= 8'(1 << $urandom_range(0, 7));
      fr.push_back(cs);
    end
    if (kind == 9) begin
      cut = $urandom_range(1, fr.size() - 1);
      for (int i = 0; i < cut; i++) send(fr[i], $urandom_range(0, 2));
      idle($urandom_range(0, 1) ? TIMEOUT_CLKS : TIMEOUT_CLKS - 1);
    end else begin
      foreach (fr[i]) send(fr[i], pick_gap());
    end
    if ($urandom_range(0, 2) == 0) ack();
  endtask

  initial begin
    i_Reset_n   = 1'b1;
    i_RX_DV     = 1'b0;
    i_RX_Byte   = 8'h00;
    i_Frame_Ack = 1'b0;
    i_Rd_Addr   = '0;
    model_reset();
    #2;
    do_reset();

    // Valid frame preceded by noise; check readback against literal values.
    send_seq('{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    check("t1_ready", o_Frame_Ready, 1'b1);
    check("t1_len", o_Frame_Len, 8'd3);
    peek(0, 8'h11, "t1_rd0");
    peek(1, 8'h22, "t1_rd1");
    peek(2, 8'h33, "t1_rd2");
    ack();

    // Bad checksum.
    send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
    check("t2_code", o_Err_Code, ERR_CSUM);
    check("t2_ready", o_Frame_Ready, 1'b0);

    // Bad lengths, then a one-byte frame.
    send_seq('{8'hA5, 8'h00});
    check("t3_code0", o_Err_Code, ERR_LEN);
    send_seq('{8'hA5, 8'h11});
    check("t3_code1", o_Err_Code, ERR_LEN);
    send_seq('{8'hA5, 8'h01, 8'h5A, 8'h5B});
    check("t3_ready", o_Frame_Ready, 1'b1);
    peek(0, 8'h5A, "t3_rd0");
    ack();

    // Timeout after 11, then a byte landing exactly on the timeout cycle.
    send_seq('{8'hA5, 8'h03, 8'h11});
    idle(TIMEOUT_CLKS - 1);
    check("t4_no_err_yet", o_Err, 1'b0);
    idle(1);
    check("t4_err", o_Err, 1'b1);
    check("t4_code", o_Err_Code, ERR_TIMEOUT);
    send_seq('{8'hA5, 8'h03, 8'h11});
    send(8'h22, TIMEOUT_CLKS - 1);
    check("t4b_no_err", o_Err, 1'b0);
    send_seq('{8'h33, 8'h03});
    check("t4b_ready", o_Frame_Ready, 1'b1);
    ack();

    // Overrun: A held, B dropped, then C after ack.
    send_seq('{8'hA5, 8'h02, 8'hA1, 8'hA2, 8'h02 ^ 8'hA1 ^ 8'hA2});
    send_seq('{8'hA5, 8'h02, 8'hB1, 8'hB2, 8'h02 ^ 8'hB1 ^ 8'hB2});
    check("t5_code", o_Err_Code, ERR_OVERRUN);
    peek(0, 8'hA1, "t5_rdA0");
    peek(1, 8'hA2, "t5_rdA1");
    ack();
    send_seq('{8'hA5, 8'h02, 8'hC1, 8'hC2, 8'h02 ^ 8'hC1 ^ 8'hC2});
    check("t5_ready", o_Frame_Ready, 1'b1);
    peek(0, 8'hC1, "t5_rdC0");
    peek(1, 8'hC2, "t5_rdC1");

    // Reset mid-payload, then a normal frame.
    send_seq('{8'hA5, 8'h04, 8'h10, 8'h20});
    do_reset();
    send_seq('{8'hA5, 8'h02, 8'h77, 8'h88, 8'h02 ^ 8'h77 ^ 8'h88});
    check("t6_ready", o_Frame_Ready, 1'b1);
    peek(1, 8'h88, "t6_rd1");
    ack();

    // Randomized traffic with acks sprinkled into idle cycles.
    rand_ack = 1'b1;
    for (int f = 0; f < 300; f++) random_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
